// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage occupancy encoding and the NOP payload.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Payload presented by an empty stage; wide enough for any legal WIDTH.
  localparam logic [63:0] NOP_VAL = 64'd0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones.
// Latency 1 cycle from inc to count; no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register with flush and stall counter.
// Latency 1 cycle; in_ready/out_valid come straight from state, so out_ready never reaches in_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_VAL),
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_t     state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_fire, out_fire;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt = ST_ONE;
          main_nxt  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire) begin
          state_nxt = ST_FULL;
          skid_nxt  = in_data;
        end else if (out_fire) begin
          // Reload NOP so an empty stage always shows RESET_VAL.
          state_nxt = ST_EMPTY;
          main_nxt  = RESET_VAL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_nxt = ST_ONE;
          main_nxt  = skid_q;
          skid_nxt  = RESET_VAL;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        main_nxt  = RESET_VAL;
        skid_nxt  = RESET_VAL;
      end
    endcase
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = RESET_VAL;
      skid_nxt  = RESET_VAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default 32-bit instance plus an 8-bit, 4-bit-counter instance.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        flush_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [31:0] in_data_a = '0;
  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic [15:0] stall_cnt_a;

  logic        flush_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [7:0]  in_data_b = '0;
  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_data_b;
  logic [3:0]  stall_cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a),
    .stall_cnt (stall_cnt_a)
  );

  pipe_stage_reg #(
    .WIDTH (8),
    .CNT_W (4)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .stall_cnt (stall_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Under reset, before any clock edge.
    #2;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready",  in_ready_a,  1);
    check("rst_out_data",  out_data_a,  0);
    check("rst_stall_cnt", stall_cnt_a, 0);
    step();
    reset = 1'b0;
    step();
    check("idle_out_valid", out_valid_a, 0);
    check("idle_in_ready",  in_ready_a,  1);
    check("idle_out_data",  out_data_a,  0);
    check("idle_stall_cnt", stall_cnt_a, 0);

    // Back-to-back stream, downstream always ready.
    out_ready_a = 1'b1; in_valid_a = 1'b1; in_data_a = 32'h11;
    step();
    check("strm_11_vld", out_valid_a, 1);
    check("strm_11", out_data_a, 32'h11);
    in_data_a = 32'h22;
    step();
    check("strm_22", out_data_a, 32'h22);
    check("strm_22_rdy", in_ready_a, 1);
    in_data_a = 32'h33;
    step();
    check("strm_33", out_data_a, 32'h33);
    in_valid_a = 1'b0;
    step();
    check("strm_drain_vld",  out_valid_a, 0);
    check("strm_drain_data", out_data_a,  0);

    // Fill both entries with downstream stalled.
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hA1;
    step();
    check("stall_a1_rdy", in_ready_a, 1);
    check("stall_a1_cnt", stall_cnt_a, 0);
    in_data_a = 32'hA2;
    step();
    check("stall_full_rdy", in_ready_a, 0);
    check("stall_hold_a1",  out_data_a, 32'hA1);
    in_valid_a = 1'b0;
    step();
    step();
    check("stall_cnt_3",     stall_cnt_a, 3);
    check("stall_still_a1",  out_data_a, 32'hA1);
    out_ready_a = 1'b1;
    step();
    check("drain_a2",     out_data_a, 32'hA2);
    check("drain_a2_vld", out_valid_a, 1);
    check("drain_a2_rdy", in_ready_a, 1);
    step();
    check("drain_empty_vld", out_valid_a, 0);
    check("drain_cnt_hold",  stall_cnt_a, 3);

    // Flush while full, with a new entry offered at the same time.
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hB1;
    step();
    in_data_a = 32'hB2;
    step();
    check("flush_pre_rdy", in_ready_a, 0);
    flush_a = 1'b1; in_data_a = 32'hB3;
    step();
    check("flush_vld",  out_valid_a, 0);
    check("flush_data", out_data_a,  0);
    check("flush_rdy",  in_ready_a,  1);
    check("flush_cnt",  stall_cnt_a, 5);
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    step();
    check("flush_no_b3", out_valid_a, 0);

    // Flush in ONE drops the entry accepted in the same cycle.
    in_valid_a = 1'b1; in_data_a = 32'hC1;
    step();
    check("one_c1", out_data_a, 32'hC1);
    flush_a = 1'b1; in_data_a = 32'hC2;
    step();
    flush_a = 1'b0; in_valid_a = 1'b0;
    check("flush_one_vld", out_valid_a, 0);
    step();
    check("flush_one_no_c2", out_valid_a, 0);

    // Asynchronous reset while full takes effect without a clock edge.
    out_ready_a = 1'b0; in_valid_a = 1'b1; in_data_a = 32'hD1;
    step();
    in_data_a = 32'hD2;
    step();
    in_valid_a = 1'b0;
    check("pre_rst_cnt", stall_cnt_a, 6);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vld",  out_valid_a, 0);
    check("async_rst_rdy",  in_ready_a,  1);
    check("async_rst_data", out_data_a,  0);
    check("async_rst_cnt",  stall_cnt_a, 0);
    reset = 1'b0;
    out_ready_a = 1'b1; in_valid_a = 1'b1; in_data_a = 32'hE1;
    step();
    check("post_rst_e1", out_data_a, 32'hE1);
    in_valid_a = 1'b0;
    step();
    check("post_rst_empty", out_valid_a, 0);

    // 8-bit instance: stream, then saturate the 4-bit counter.
    out_ready_b = 1'b1; in_valid_b = 1'b1; in_data_b = 8'h01;
    step();
    check("w8_01", out_data_b, 8'h01);
    in_data_b = 8'hFF;
    step();
    check("w8_ff", out_data_b, 8'hFF);
    check("w8_ff_vld", out_valid_b, 1);
    in_valid_b = 1'b0;
    step();
    check("w8_empty", out_valid_b, 0);
    out_ready_b = 1'b0; in_valid_b = 1'b1; in_data_b = 8'h5A;
    step();
    in_valid_b = 1'b0;
    check("w8_cnt_0", stall_cnt_b, 0);
    repeat (14) step();
    check("w8_cnt_14", stall_cnt_b, 14);
    repeat (6) step();
    check("w8_cnt_sat", stall_cnt_b, 15);
    repeat (3) step();
    check("w8_cnt_hold", stall_cnt_b, 15);
    check("w8_data_stable", out_data_b, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
